// File: rtl/iterative_alu.sv
// iterative_alu: multi-cycle ALU for the MIPS execute stage.
//   Single-cycle ops (ADD/SUB/AND/OR/XOR/NOR/SLT/SLTU) go through one register stage.
//   MULT/MULTU use a radix-2^MUL_STEP shift-add on operand magnitudes.
//   DIV/DIVU use restoring division on magnitudes, one quotient bit per cycle.
//   A FIX state applies the sign correction and writes the HI/LO result.
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   in_valid/in_ready     request handshake; in_ready = (state == IDLE)
//   op, a, b              op code and operands, latched when a request is accepted
//   flush                 synchronous abort of any in-flight op, including a pending single-cycle op
//   out_valid             one-cycle pulse when result_lo/result_hi/flags update
//   result_lo/result_hi   {hi,lo} = product, lo = quotient, hi = remainder, hi = 0 otherwise
//   div_zero, illegal     status of the last completed op
module iterative_alu #(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             out_valid,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             div_zero,
    output logic             illegal
);
    localparam int STEPS = WIDTH / MUL_STEP;
    localparam int CW    = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
    state_t state, state_nx;

    logic [3:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic               pend;        // a single-cycle op was accepted last edge
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] prod, mcand; // mcand is |a| pre-shifted to the current digit
    logic [WIDTH-1:0]   mplier, rem, quo, dvsr;

    assign in_ready = (state == IDLE);

    logic accept, is_mul_in, is_div_in, sgn_in;
    logic [WIDTH-1:0] a_mag_in, b_mag_in;
    assign accept    = in_valid & in_ready & ~flush;
    assign is_mul_in = (op[3:1] == 3'b100);
    assign is_div_in = (op[3:1] == 3'b101);
    assign sgn_in    = ~op[0];       // MULT/DIV are signed, MULTU/DIVU unsigned
    assign a_mag_in  = (sgn_in & a[WIDTH-1]) ? -a : a;
    assign b_mag_in  = (sgn_in & b[WIDTH-1]) ? -b : b;

    // Multiply step: one MUL_STEP-bit digit of |b| times pre-shifted |a|.
    logic [2*WIDTH-1:0] partial;
    assign partial = mcand * {{(2*WIDTH-MUL_STEP){1'b0}}, mplier[MUL_STEP-1:0]};

    // Restoring divide step; diff sign bit is the "does not fit" flag.
    logic [WIDTH:0] shifted, diff;
    logic           take;
    assign shifted = {rem, quo[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvsr};
    assign take    = ~diff[WIDTH];

    // Sign correction, computed from the latched operands.
    logic               sgn_q, p_neg, q_neg, r_neg;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    assign sgn_q    = ~op_q[0];
    assign p_neg    = sgn_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
    assign q_neg    = p_neg;
    assign r_neg    = sgn_q & a_q[WIDTH-1];
    assign prod_fix = p_neg ? -prod : prod;
    assign quo_fix  = q_neg ? -quo : quo;
    assign rem_fix  = r_neg ? -rem : rem;

    // Single-cycle result from the latched request.
    logic [WIDTH-1:0] sc_lo;
    logic             sc_ill;
    always_comb begin
        sc_lo  = '0;
        sc_ill = 1'b0;
        case (op_q)
            4'b0000: sc_lo = a_q + b_q;
            4'b0001: sc_lo = a_q - b_q;
            4'b0010: sc_lo = a_q & b_q;
            4'b0011: sc_lo = a_q | b_q;
            4'b0100: sc_lo = a_q ^ b_q;
            4'b0101: sc_lo = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            4'b0110: sc_lo = {{(WIDTH-1){1'b0}}, (a_q < b_q)};
            4'b0111: sc_lo = ~(a_q | b_q);
            default: sc_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) begin
                      if (is_mul_in)      state_nx = MUL;
                      else if (is_div_in) state_nx = DIV;
                  end
            MUL:  if (cnt == CW'(STEPS - 1)) state_nx = FIX;
            DIV:  if (cnt == CW'(WIDTH - 1)) state_nx = FIX;
            FIX:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (flush) state_nx = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            pend      <= 1'b0;
            cnt       <= '0;
            prod      <= '0;
            mcand     <= '0;
            mplier    <= '0;
            rem       <= '0;
            quo       <= '0;
            dvsr      <= '0;
            out_valid <= 1'b0;
            result_lo <= '0;
            result_hi <= '0;
            div_zero  <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            // Retire the previous single-cycle op; this can coincide with a new accept.
            if (pend && !flush) begin
                result_lo <= sc_lo;
                result_hi <= '0;
                div_zero  <= 1'b0;
                illegal   <= sc_ill;
                out_valid <= 1'b1;
            end
            pend <= accept & ~is_mul_in & ~is_div_in;

            if (accept) begin
                op_q   <= op;
                a_q    <= a;
                b_q    <= b;
                cnt    <= '0;
                prod   <= '0;
                mcand  <= {{WIDTH{1'b0}}, a_mag_in};
                mplier <= b_mag_in;
                rem    <= '0;
                quo    <= a_mag_in;
                dvsr   <= b_mag_in;
            end

            case (state)
                MUL: begin
                    prod   <= prod + partial;
                    mcand  <= mcand << MUL_STEP;
                    mplier <= mplier >> MUL_STEP;
                    cnt    <= cnt + CW'(1);
                end
                DIV: begin
                    rem <= take ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], take};
                    cnt <= cnt + CW'(1);
                end
                FIX: if (!flush) begin
                    out_valid <= 1'b1;
                    illegal   <= 1'b0;
                    if (!op_q[1]) begin
                        {result_hi, result_lo} <= prod_fix;
                        div_zero <= 1'b0;
                    end else if (b_q == '0) begin
                        // Divide by zero still ran full latency; report a fixed pattern.
                        result_lo <= '1;
                        result_hi <= a_q;
                        div_zero  <= 1'b1;
                    end else begin
                        result_lo <= quo_fix;
                        result_hi <= rem_fix;
                        div_zero  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_iterative_alu.sv
// Bench for iterative_alu: directed table of single-cycle ops, directed multi-cycle
// corner cases, randomized ops against an arithmetic reference model, flush, reset
// mid-divide, and a WIDTH=16/MUL_STEP=4 instance.
module tb_iterative_alu;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, flush, out_valid, div_zero, illegal;
    logic [3:0]  op;
    logic [31:0] a, b, result_lo, result_hi;

    logic        in_valid16, in_ready16, flush16, out_valid16, dz16, ill16;
    logic [3:0]  op16;
    logic [15:0] a16, b16, lo16, hi16;

    int ncmp = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    iterative_alu dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .flush(flush), .out_valid(out_valid),
        .result_lo(result_lo), .result_hi(result_hi),
        .div_zero(div_zero), .illegal(illegal)
    );

    iterative_alu #(.WIDTH(16), .MUL_STEP(4)) dut16 (
        .clk(clk), .reset(reset), .in_valid(in_valid16), .in_ready(in_ready16),
        .op(op16), .a(a16), .b(b16), .flush(flush16), .out_valid(out_valid16),
        .result_lo(lo16), .result_hi(hi16),
        .div_zero(dz16), .illegal(ill16)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b, lo, hi;
        logic        ill;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: {illegal, div_zero, hi, lo} from the op definitions with plain arithmetic.
    function automatic logic [65:0] model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] lo, hi;
        logic        dz, ill;
        logic [63:0] p;
        longint      sx, sy;
        lo = 0; hi = 0; dz = 0; ill = 0;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            4'd0:  lo = x + y;
            4'd1:  lo = x - y;
            4'd2:  lo = x & y;
            4'd3:  lo = x | y;
            4'd4:  lo = x ^ y;
            4'd5:  lo = (sx < sy) ? 32'd1 : 32'd0;
            4'd6:  lo = (x < y) ? 32'd1 : 32'd0;
            4'd7:  lo = ~(x | y);
            4'd8:  begin p = 64'(sx * sy); {hi, lo} = p; end
            4'd9:  begin p = 64'(x) * 64'(y); {hi, lo} = p; end
            4'd10, 4'd11: begin
                if (y == 0) begin
                    lo = 32'hFFFF_FFFF; hi = x; dz = 1;
                end else if (o == 4'd10) begin
                    lo = 32'(sx / sy); hi = 32'(sx % sy);
                end else begin
                    lo = x / y; hi = x % y;
                end
            end
            default: ill = 1;
        endcase
        return {ill, dz, hi, lo};
    endfunction

    function automatic int latency(input logic [3:0] o);
        if (o[3:1] == 3'b100) return 5;
        if (o[3:1] == 3'b101) return 33;
        return 1;
    endfunction

    // Called at #1 after an edge with in_ready high; returns during the out_valid cycle.
    task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] elo, input logic [31:0] ehi,
                         input logic edz, input logic eill, input int lat, input string nm);
        int n;
        in_valid = 1; op = o; a = x; b = y;
        tick();
        in_valid = 0; a = $urandom; b = $urandom; op = 4'($urandom);
        n = 0;
        while (!out_valid && n < lat + 5) begin
            if (n == 1 && lat > 1) chk({nm, " busy_ready"}, 64'(in_ready), 64'd0);
            tick();
            n++;
        end
        chk({nm, " latency"}, 64'(n), 64'(lat));
        chk({nm, " lo"}, 64'(result_lo), 64'(elo));
        chk({nm, " hi"}, 64'(result_hi), 64'(ehi));
        chk({nm, " div_zero"}, 64'(div_zero), 64'(edz));
        chk({nm, " illegal"}, 64'(illegal), 64'(eill));
        chk({nm, " ready_on_valid"}, 64'(in_ready), 64'd1);
    endtask

    task automatic issue16(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                           input logic [15:0] elo, input logic [15:0] ehi,
                           input logic edz, input int lat, input string nm);
        int n;
        in_valid16 = 1; op16 = o; a16 = x; b16 = y;
        tick();
        in_valid16 = 0; a16 = 16'($urandom); b16 = 16'($urandom);
        n = 0;
        while (!out_valid16 && n < lat + 5) begin
            tick();
            n++;
        end
        chk({nm, " latency"}, 64'(n), 64'(lat));
        chk({nm, " lo"}, 64'(lo16), 64'(elo));
        chk({nm, " hi"}, 64'(hi16), 64'(ehi));
        chk({nm, " div_zero"}, 64'(dz16), 64'(edz));
        chk({nm, " illegal"}, 64'(ill16), 64'd0);
    endtask

    vec_t tv[10];
    logic [31:0] corner[5];
    logic [65:0] m;
    logic [31:0] keep_lo, keep_hi;
    int ov_seen;

    initial begin
        tv[0] = '{4'h0, 32'hFFFF_FFFF, 32'h1,         32'h0000_0000, 32'h0, 1'b0};
        tv[1] = '{4'h1, 32'h3,         32'h5,         32'hFFFF_FFFE, 32'h0, 1'b0};
        tv[2] = '{4'h5, 32'hFFFF_FFFF, 32'h1,         32'h1,         32'h0, 1'b0};
        tv[3] = '{4'h6, 32'hFFFF_FFFF, 32'h1,         32'h0,         32'h0, 1'b0};
        tv[4] = '{4'h2, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 32'h0, 1'b0};
        tv[5] = '{4'h3, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 32'h0, 1'b0};
        tv[6] = '{4'h4, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 32'h0, 1'b0};
        tv[7] = '{4'h7, 32'h0,         32'h0,         32'hFFFF_FFFF, 32'h0, 1'b0};
        tv[8] = '{4'hD, 32'h5,         32'h6,         32'h0,         32'h0, 1'b1};
        tv[9] = '{4'h0, 32'h1,         32'h2,         32'h3,         32'h0, 1'b0};
        corner[0] = 32'h8000_0000; corner[1] = 32'hFFFF_FFFF; corner[2] = 32'h0;
        corner[3] = 32'h1;         corner[4] = 32'h7FFF_FFFF;

        reset = 1; in_valid = 0; flush = 0; op = 0; a = 0; b = 0;
        in_valid16 = 0; flush16 = 0; op16 = 0; a16 = 0; b16 = 0;
        repeat (3) tick();
        reset = 0;
        chk("reset in_ready", 64'(in_ready), 64'd1);
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset lo", 64'(result_lo), 64'd0);
        chk("reset hi", 64'(result_hi), 64'd0);
        chk("reset flags", 64'({div_zero, illegal}), 64'd0);

        // Back-to-back single-cycle ops: out_valid must stay high every cycle.
        in_valid = 1; op = tv[0].op; a = tv[0].a; b = tv[0].b;
        tick();
        for (int i = 0; i < 10; i++) begin
            if (i + 1 < 10) begin
                op = tv[i+1].op; a = tv[i+1].a; b = tv[i+1].b;
            end else begin
                in_valid = 0;
            end
            tick();
            chk($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("vec%0d lo", i), 64'(result_lo), 64'(tv[i].lo));
            chk($sformatf("vec%0d hi", i), 64'(result_hi), 64'(tv[i].hi));
            chk($sformatf("vec%0d illegal", i), 64'(illegal), 64'(tv[i].ill));
        end
        tick();
        chk("single pulse end", 64'(out_valid), 64'd0);

        // Multi-cycle corners, issued back-to-back.
        issue(4'h8, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 32'hFFFF_FFFF, 0, 0, 5, "mult -3*7");
        issue(4'h9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 0, 0, 5, "multu max");
        issue(4'hA, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0, 0, 33, "div -7/2");
        issue(4'hA, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 0, 0, 33, "div min/-1");
        issue(4'hB, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1, 0, 33, "divu 5/0");
        issue(4'h0, 32'd1, 32'd1, 32'd2, 32'd0, 0, 0, 1, "add after dz");

        // Randomized ops against the reference model.
        for (int i = 0; i < 40; i++) begin
            logic [3:0]  o;
            logic [31:0] x, y;
            o = 4'($urandom_range(0, 15));
            x = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            y = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            if ($urandom_range(0, 1) == 1) y = y >> $urandom_range(0, 31);
            m = model(o, x, y);
            issue(o, x, y, m[31:0], m[63:32], m[64], m[65], latency(o), $sformatf("rand%0d op%0d", i, o));
        end

        // Flush mid-multiply, then flush beating an accept in IDLE.
        issue(4'hB, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1, 0, 33, "divu 5/0 again");
        keep_lo = result_lo; keep_hi = result_hi;
        in_valid = 1; op = 4'h8; a = 32'd3; b = 32'd7;
        tick();
        in_valid = 0;
        ov_seen = 0;
        tick();
        ov_seen += int'(out_valid);
        flush = 1;
        tick();
        ov_seen += int'(out_valid);
        chk("flush ready", 64'(in_ready), 64'd1);
        in_valid = 1; op = 4'h0; a = 32'd1; b = 32'd1;
        tick();
        flush = 0; in_valid = 0;
        for (int i = 0; i < 8; i++) begin
            ov_seen += int'(out_valid);
            tick();
        end
        chk("flush no out_valid", 64'(ov_seen), 64'd0);
        chk("flush ready later", 64'(in_ready), 64'd1);
        chk("flush keep lo", 64'(result_lo), 64'(keep_lo));
        chk("flush keep hi", 64'(result_hi), 64'(keep_hi));
        chk("flush keep dz", 64'(div_zero), 64'd1);

        // Reset in divide iteration 10.
        in_valid = 1; op = 4'hA; a = 32'd100; b = 32'd7;
        tick();
        in_valid = 0;
        repeat (10) tick();
        reset = 1;
        #1;
        chk("midreset out_valid", 64'(out_valid), 64'd0);
        chk("midreset ready", 64'(in_ready), 64'd1);
        chk("midreset lo", 64'(result_lo), 64'd0);
        chk("midreset hi", 64'(result_hi), 64'd0);
        chk("midreset flags", 64'({div_zero, illegal}), 64'd0);
        tick();
        reset = 0;
        tick();
        chk("post reset ready", 64'(in_ready), 64'd1);
        chk("post reset quiet", 64'(out_valid), 64'd0);
        issue(4'hA, 32'd100, 32'd7, 32'd14, 32'd2, 0, 0, 33, "div after reset");

        // Narrow instance.
        issue16(4'h9, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 0, 5, "w16 multu");
        issue16(4'h8, 16'hFFFD, 16'd7, 16'hFFEB, 16'hFFFF, 0, 5, "w16 mult");
        issue16(4'hA, 16'hFFF9, 16'd2, 16'hFFFD, 16'hFFFF, 0, 17, "w16 div");
        issue16(4'hB, 16'd9, 16'd0, 16'hFFFF, 16'd9, 1, 17, "w16 divu0");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
